// File: rtl/debug_access_master.sv
// debug_access_master
//
// Single-outstanding initiator for the core's debug slave port. A command
// accepted on the cmd_* valid/ready channel is presented to the core as a
// debug request. The master waits for the grant and then for read-valid, and
// returns the result on the rsp_* valid/ready channel. Separate timeouts cover
// the grant wait and the rvalid wait. When either timeout expires, the master
// returns an error response instead of hanging.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake (ready only while idle)
//   cmd_addr_i/we_i/wdata_i  command fields, captured on acceptance
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          read data (0 for writes and errors)
//   rsp_err_o            transaction timed out
//   debug_req_o          request to core, high exactly while in REQ
//   debug_gnt_i          core grant
//   debug_rvalid_i       core response valid
//   debug_addr_o/we_o/wdata_o  command fields to core, held after REQ
//   debug_rdata_i        read data from core
//   busy_o               a transaction is in flight
module debug_access_master #(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_we_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  debug_req_o,
  input  logic                  debug_gnt_i,
  input  logic                  debug_rvalid_i,
  output logic [ADDR_WIDTH-1:0] debug_addr_o,
  output logic                  debug_we_o,
  output logic [31:0]           debug_wdata_o,
  input  logic [31:0]           debug_rdata_i,
  output logic                  busy_o
);

  // A zero timeout would give a zero-width counter, so keep at least one bit.
  // The counter is unused in that case.
  localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLIM_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TLIM = TLIM_I[TW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e                state_q;
  logic [TW-1:0]         timer_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  expired_d;
  logic [31:0]           rdata_d;

  // The timer counts the cycles already spent in the current phase. It
  // expires on the last permitted cycle, so REQ or WAIT lasts exactly
  // TIMEOUT_CYCLES cycles. A grant or rvalid in that cycle still takes
  // priority over the timeout.
  assign expired_d = (TIMEOUT_CYCLES != 0) && (timer_q == TLIM);
  assign rdata_d   = we_q ? 32'h0 : debug_rdata_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            we_q    <= cmd_we_i;
            wdata_q <= cmd_wdata_i;
            timer_q <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (debug_gnt_i) begin
            timer_q <= '0;
            // The core may return rvalid in the same cycle as the grant.
            if (debug_rvalid_i) begin
              rdata_q <= rdata_d;
              err_q   <= 1'b0;
              state_q <= RSP;
            end else begin
              state_q <= WAIT;
            end
          end else if (expired_d) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state_q <= RSP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT: begin
          if (debug_rvalid_i) begin
            rdata_q <= rdata_d;
            err_q   <= 1'b0;
            state_q <= RSP;
          end else if (expired_d) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state_q <= RSP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The handshake and request outputs are decoded directly from state. The
  // command fields stay registered and hold their last value after REQ.
  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign debug_req_o   = (state_q == REQ);
  assign rsp_valid_o   = (state_q == RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign debug_addr_o  = addr_q;
  assign debug_we_o    = we_q;
  assign debug_wdata_o = wdata_q;

endmodule

// File: tb/tb_debug_access_master.sv
// tb_debug_access_master
//
// Randomised and directed bench for debug_access_master with an 8-cycle
// timeout. Each transaction is described by the cycle of the REQ phase in
// which the core grants, the WAIT cycle in which it answers, and the core's
// read data. A reference model derives the expected REQ length, WAIT length,
// error flag and read data from these values.
module tb_debug_access_master;

  localparam int AW = 15;
  localparam int TC = 8;
  localparam int NEVER = 255;

  logic          clk_i;
  logic          rstn_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic          cmd_we_i;
  logic [31:0]   cmd_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          debug_req_o;
  logic          debug_gnt_i;
  logic          debug_rvalid_i;
  logic [AW-1:0] debug_addr_o;
  logic          debug_we_o;
  logic [31:0]   debug_wdata_o;
  logic [31:0]   debug_rdata_i;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  debug_access_master #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_we_i      (cmd_we_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .debug_req_o   (debug_req_o),
    .debug_gnt_i   (debug_gnt_i),
    .debug_rvalid_i(debug_rvalid_i),
    .debug_addr_o  (debug_addr_o),
    .debug_we_o    (debug_we_o),
    .debug_wdata_o (debug_wdata_o),
    .debug_rdata_i (debug_rdata_i),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model.
  // gd: REQ cycle (0-based) in which the core grants.
  // rd: 0 means rvalid arrives with the grant; k >= 1 means rvalid arrives in
  //     the k-th WAIT cycle.
  // Each phase may last at most TC cycles.
  task automatic model(input int gd, input int rd, input logic we, input logic [31:0] core,
                       output logic e_err, output logic [31:0] e_rdata,
                       output int e_req, output int e_wait);
    if (gd >= TC) begin
      e_req  = TC;
      e_wait = 0;
      e_err  = 1'b1;
    end else begin
      e_req = gd + 1;
      if (rd == 0) begin
        e_wait = 0;
        e_err  = 1'b0;
      end else if (rd <= TC) begin
        e_wait = rd;
        e_err  = 1'b0;
      end else begin
        e_wait = TC;
        e_err  = 1'b1;
      end
    end
    e_rdata = (e_err || we) ? 32'h0 : core;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready_o, 1);
    check({pfx, "_rsp_valid"}, rsp_valid_o, 0);
    check({pfx, "_rsp_rdata"}, rsp_rdata_o, 0);
    check({pfx, "_rsp_err"}, rsp_err_o, 0);
    check({pfx, "_debug_req"}, debug_req_o, 0);
    check({pfx, "_debug_addr"}, debug_addr_o, 0);
    check({pfx, "_debug_we"}, debug_we_o, 0);
    check({pfx, "_debug_wdata"}, debug_wdata_o, 0);
    check({pfx, "_busy"}, busy_o, 0);
  endtask

  task automatic run_txn(input logic [AW-1:0] a, input logic we, input logic [31:0] wd,
                         input int gd, input int rd, input logic [31:0] core, input int hold);
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_req, e_wait;
    int          c, w;
    model(gd, rd, we, core, e_err, e_rdata, e_req, e_wait);

    @(negedge clk_i);
    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_we_i    = we;
    cmd_wdata_i = wd;
    @(negedge clk_i);
    // Scramble the command bus to confirm the fields are registered.
    cmd_valid_i = 1'b0;
    cmd_addr_i  = AW'($urandom);
    cmd_we_i    = 1'($urandom_range(0, 1));
    cmd_wdata_i = $urandom;
    check("busy_after_accept", busy_o, 1);

    c = 0;
    while (debug_req_o && c < 300) begin
      check("req_addr", debug_addr_o, a);
      check("req_we", debug_we_o, we);
      check("req_wdata", debug_wdata_o, wd);
      check("req_cmd_ready", cmd_ready_o, 0);
      debug_gnt_i    = (c == gd);
      debug_rdata_i  = core;
      // Stray rvalid without a grant must be ignored.
      debug_rvalid_i = (c == gd) ? (rd == 0) : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      c++;
    end
    debug_gnt_i    = 1'b0;
    debug_rvalid_i = 1'b0;
    check("req_cycles", c, e_req);

    w = 0;
    while (busy_o && !rsp_valid_o && !debug_req_o && w < 300) begin
      w++;
      debug_rvalid_i = (w == rd);
      debug_rdata_i  = (w == rd) ? core : $urandom;
      @(negedge clk_i);
    end
    debug_rvalid_i = 1'b0;
    check("wait_cycles", w, e_wait);

    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_rdata", rsp_rdata_o, e_rdata);
    check("rsp_err", rsp_err_o, e_err);

    for (int i = 0; i < hold; i++) begin
      rsp_ready_i    = 1'b0;
      debug_rvalid_i = 1'($urandom_range(0, 1));
      debug_rdata_i  = $urandom;
      @(negedge clk_i);
      check("hold_rsp_valid", rsp_valid_o, 1);
      check("hold_rsp_rdata", rsp_rdata_o, e_rdata);
      check("hold_rsp_err", rsp_err_o, e_err);
      check("hold_cmd_ready", cmd_ready_o, 0);
    end
    debug_rvalid_i = 1'b0;
    rsp_ready_i    = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("done_rsp_valid", rsp_valid_o, 0);
    check("done_cmd_ready", cmd_ready_o, 1);
    check("done_busy", busy_o, 0);
    check("done_req", debug_req_o, 0);
    check("done_addr_hold", debug_addr_o, a);
    check("done_wdata_hold", debug_wdata_o, wd);
  endtask

  // mode 0: reset while in REQ; mode 1: reset while a response is pending.
  task automatic reset_mid(input int mode);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 15'h1234;
    cmd_we_i    = 1'b0;
    cmd_wdata_i = 32'hA5A5A5A5;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    if (mode == 1) begin
      debug_gnt_i    = 1'b1;
      debug_rvalid_i = 1'b1;
      debug_rdata_i  = 32'h0BADF00D;
      @(negedge clk_i);
      debug_gnt_i    = 1'b0;
      debug_rvalid_i = 1'b0;
      check("pre_reset_rsp_valid", rsp_valid_o, 1);
      check("pre_reset_rsp_rdata", rsp_rdata_o, 32'h0BADF00D);
    end else begin
      @(negedge clk_i);
      @(negedge clk_i);
      check("pre_reset_req", debug_req_o, 1);
    end
    rstn_i = 1'b0;
    #1;
    check_reset_outputs(mode == 1 ? "rst_rsp" : "rst_req");
    @(negedge clk_i);
    check("in_reset_rsp_valid", rsp_valid_o, 0);
    rstn_i      = 1'b1;
    // Present a write in the first cycle after release. The master must
    // accept it at the next edge.
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 15'h0777;
    cmd_we_i    = 1'b1;
    cmd_wdata_i = 32'h55AA55AA;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("post_rst_req", debug_req_o, 1);
    check("post_rst_addr", debug_addr_o, 15'h0777);
    check("post_rst_no_rsp", rsp_valid_o, 0);
    debug_gnt_i    = 1'b1;
    debug_rvalid_i = 1'b1;
    debug_rdata_i  = 32'hFFFFFFFF;
    @(negedge clk_i);
    debug_gnt_i    = 1'b0;
    debug_rvalid_i = 1'b0;
    check("post_rst_rsp_valid", rsp_valid_o, 1);
    check("post_rst_rsp_rdata", rsp_rdata_o, 0);
    check("post_rst_rsp_err", rsp_err_o, 0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("post_rst_idle", cmd_ready_o, 1);
  endtask

  initial begin
    rstn_i         = 1'b0;
    cmd_valid_i    = 1'b0;
    cmd_addr_i     = '0;
    cmd_we_i       = 1'b0;
    cmd_wdata_i    = 32'h0;
    rsp_ready_i    = 1'b0;
    debug_gnt_i    = 1'b0;
    debug_rvalid_i = 1'b0;
    debug_rdata_i  = 32'h0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rstn_i = 1'b1;

    // Directed cases.
    run_txn(15'h2000, 1'b0, 32'h0,        0,     1,     32'hDEADBEEF, 0);
    run_txn(15'h0004, 1'b1, 32'h12345678, 5,     1,     32'hCAFEF00D, 0);
    run_txn(15'h0100, 1'b0, 32'h0,        NEVER, 0,     32'h11111111, 0);
    run_txn(15'h0101, 1'b0, 32'h0,        0,     2,     32'h22222222, 0);
    run_txn(15'h0102, 1'b0, 32'h0,        1,     TC,    32'h33333333, 0);
    run_txn(15'h0103, 1'b0, 32'h0,        2,     NEVER, 32'h44444444, 0);
    run_txn(15'h0104, 1'b0, 32'h0,        TC-1,  0,     32'h55555555, 10);
    run_txn(15'h0105, 1'b0, 32'h0,        TC,    1,     32'h66666666, 2);
    run_txn(15'h0106, 1'b0, 32'h0,        0,     TC+1,  32'h77777777, 0);

    reset_mid(0);
    reset_mid(1);

    // Randomised transactions.
    for (int n = 0; n < 40; n++) begin
      int          gd, rd, hold;
      logic        we;
      logic [AW-1:0] a;
      logic [31:0] wd, core;
      gd   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 9));
      rd   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 10));
      hold = int'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      a    = AW'($urandom);
      wd   = $urandom;
      core = $urandom;
      run_txn(a, we, wd, gd, rd, core, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
